// File: rtl/demux1to16_28bit_reg.sv
// Purpose: 1-to-16 registered demux that writes one entry per cycle, with per-entry valid bits and a 16-cycle sequential flush.
// Latency: a write is visible on OUTPUTS/VALID one edge after acceptance. WRITE_ACK is registered and appears in the cycle after an accepted write.
// Backpressure: BUSY is high for the whole flush. Writes presented while BUSY is high are dropped and are not queued.
//
// Ports:
//   CLK        - clock; all state changes on its rising edge
//   RESET      - synchronous, active-high; overrides everything
//   WRITE_EN   - write request for this cycle
//   SELECT     - target entry 0..15
//   INPUT      - write data
//   FLUSH      - start invalidating all entries (ignored while flushing)
//   OUTPUTS    - packed entries, entry i at [WIDTH*i +: WIDTH]
//   VALID      - bit i set when entry i holds written data
//   BUSY       - flush sequence in progress
//   WRITE_ACK  - one-cycle confirmation of an accepted write

module demux1to16_28bit_reg #(
    parameter int WIDTH = 28
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  WRITE_EN,
    input  logic [3:0]            SELECT,
    input  logic [WIDTH-1:0]      INPUT,
    input  logic                  FLUSH,
    output logic [16*WIDTH-1:0]   OUTPUTS,
    output logic [15:0]           VALID,
    output logic                  BUSY,
    output logic                  WRITE_ACK
);

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_FLUSHING = 1'b1
    } state_t;

    state_t             r_state;
    logic [3:0]         r_flush_idx;
    logic [WIDTH-1:0]   r_entry [16];
    logic [15:0]        r_valid;
    logic               r_write_ack;

    // FLUSH wins over a same-cycle write. Nothing is accepted during a flush.
    logic w_write_accept;
    assign w_write_accept = WRITE_EN && (r_state == ST_IDLE) && !FLUSH;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state     <= ST_IDLE;
            r_flush_idx <= 4'd0;
            r_valid     <= 16'h0000;
            r_write_ack <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                r_entry[i] <= '0;
            end
        end else begin
            r_write_ack <= w_write_accept;
            case (r_state)
                ST_IDLE: begin
                    if (FLUSH) begin
                        r_state     <= ST_FLUSHING;
                        r_flush_idx <= 4'd0;
                    end else if (WRITE_EN) begin
                        r_entry[SELECT] <= INPUT;
                        r_valid[SELECT] <= 1'b1;
                    end
                end
                ST_FLUSHING: begin
                    r_entry[r_flush_idx] <= '0;
                    r_valid[r_flush_idx] <= 1'b0;
                    // The index wraps from 15 back to 0 on the same edge that returns to idle.
                    r_flush_idx          <= r_flush_idx + 4'd1;
                    if (r_flush_idx == 4'd15) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    for (genvar g = 0; g < 16; g++) begin : g_pack
        assign OUTPUTS[WIDTH*g +: WIDTH] = r_entry[g];
    end

    assign VALID     = r_valid;
    assign BUSY      = (r_state == ST_FLUSHING);
    assign WRITE_ACK = r_write_ack;

endmodule

// File: doc/demux1to16_28bit_reg.md
DEMUX1TO16_28BIT_REG -- requirements
Module: demux1to16_28bit_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 28: bit width of each entry and of INPUT.
REQ-002 SHALL have port CLK, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port RESET, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have port WRITE_EN, input, 1: write request for the current cycle.
REQ-005 SHALL have port SELECT, input, 4: target entry index for the write, 0..15.
REQ-006 SHALL have port INPUT, input, WIDTH: write data.
REQ-007 SHALL have port FLUSH, input, 1: request to invalidate all entries.
REQ-008 SHALL have port OUTPUTS, output, 16*WIDTH: entry i at bits [WIDTH*i+WIDTH-1 : WIDTH*i], registered, for direct connection to the 16 inputs of a 16-to-1 28-bit selector.
REQ-009 SHALL have port VALID, output, 16: bit i set when entry i holds written data.
REQ-010 SHALL have port BUSY, output, 1: high while the flush sequence is in progress.
REQ-011 SHALL have port WRITE_ACK, output, 1: one-cycle pulse confirming an accepted write.

Function
REQ-012 SHALL implement a two-state FSM: IDLE and FLUSHING. BUSY = 1 exactly when state is FLUSHING.
REQ-013 Write acceptance: a write SHALL be accepted at a rising edge only when WRITE_EN = 1, state is IDLE, and FLUSH = 0.
REQ-014 On an accepted write, the edge SHALL load entry[SELECT] with INPUT and set VALID[SELECT]; all other entries and VALID bits SHALL remain unchanged.
REQ-015 Write latency SHALL be one edge: the new data and VALID bit are visible on OUTPUTS/VALID immediately after the accepting edge.
REQ-016 WRITE_ACK SHALL be registered: it is 1 during the cycle following an accepted write, otherwise 0. Back-to-back accepted writes SHALL hold WRITE_ACK high continuously.
REQ-017 Rewriting an already-valid entry SHALL overwrite its data; VALID stays 1; WRITE_ACK pulses as normal.
REQ-018 Writes presented while BUSY = 1 SHALL be dropped, with no state change and no WRITE_ACK; no queuing.
REQ-019 Flush start: FLUSH = 1 at an edge in IDLE SHALL move the FSM to FLUSHING and set a 4-bit flush index to 0.
REQ-020 In FLUSHING, each edge SHALL clear entry[index] to 0 and VALID[index] to 0, then increment index. The edge that clears index 15 SHALL return the FSM to IDLE.
REQ-021 BUSY SHALL therefore be high for exactly 16 cycles per flush. If FLUSH is sampled at edge N, entry k clears at edge N+1+k and IDLE resumes after edge N+16.
REQ-022 FLUSH asserted while in FLUSHING SHALL be ignored; no restart or extension of the sequence.
REQ-023 FLUSH and WRITE_EN asserted together in IDLE: FLUSH SHALL take priority and the write SHALL be dropped with no WRITE_ACK.
REQ-024 The flush index SHALL wrap 15 to 0 only on the FLUSHING-to-IDLE transition; it is don't-care in IDLE.
REQ-025 SELECT values SHALL all be legal. There is no out-of-range case; SELECT = 4'b1111 targets entry 15.

Reset
REQ-026 RESET = 1 at a rising edge SHALL set all entries to 0, VALID to 16'h0000, WRITE_ACK to 0, flush index to 0, and the FSM to IDLE (BUSY = 0).
REQ-027 RESET SHALL override WRITE_EN and FLUSH in the same edge, including mid-flush. The next edge with RESET = 0 SHALL behave as from IDLE.
REQ-028 RESET SHALL have no asynchronous effect; outputs change only at a clock edge.

Verification
REQ-029 Reset, then write INPUT=28'hABCDEF1, SELECT=3 -> after edge: entry3 = 28'hABCDEF1, VALID = 16'h0008, WRITE_ACK = 1 for one cycle, all other entries 0.
REQ-030 Write 16 consecutive cycles, SELECT = i, INPUT = i+1 -> VALID = 16'hFFFF, entry i = i+1, WRITE_ACK high for 16 consecutive cycles.
REQ-031 With all entries valid, pulse FLUSH at edge N and hold WRITE_EN = 1, SELECT = 0 throughout -> BUSY high for 16 cycles; entry k = 0 and VALID[k] = 0 after edge N+1+k; no WRITE_ACK during BUSY. The first write after BUSY falls is accepted.
REQ-032 In IDLE, assert FLUSH and WRITE_EN (SELECT = 5, INPUT = 28'h1234567) in the same cycle -> entry5 is not written, WRITE_ACK = 0, BUSY = 1.
REQ-033 Assert RESET at flush cycle 7 -> next edge: BUSY = 0, VALID = 0, all entries 0; a following write to SELECT = 15 is accepted normally.
